alu_iter: RTL and testbench

//  Parametrised multi-cycle ALU for the LAPIDO execute stage. Single-cycle logic/arith ops, plus variable-amount

---
 rtl/alu_iter_pkg.sv | 51 +++++
 rtl/alu_iter_step.sv | 71 +++++++
 rtl/alu_iter.sv | 187 ++++++++++++++++++
 tb/tb_alu_iter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_iter_pkg.sv
// Shared encodings for the iterative ALU: function codes, flag bit indices,
// FSM state type and small decode/flag helpers.
package alu_iter_pkg;

  localparam logic [5:0] FN_ADD  = 6'h00;
  localparam logic [5:0] FN_SUB  = 6'h01;
  localparam logic [5:0] FN_AND  = 6'h02;
  localparam logic [5:0] FN_NAND = 6'h03;
  localparam logic [5:0] FN_OR   = 6'h04;
  localparam logic [5:0] FN_NOR  = 6'h05;
  localparam logic [5:0] FN_XOR  = 6'h06;
  localparam logic [5:0] FN_XNOR = 6'h07;
  localparam logic [5:0] FN_NOT  = 6'h08;
  localparam logic [5:0] FN_SLT  = 6'h09;
  localparam logic [5:0] FN_ASL  = 6'h0A;
  localparam logic [5:0] FN_ASR  = 6'h0B;
  localparam logic [5:0] FN_LSL  = 6'h0C;
  localparam logic [5:0] FN_LSR  = 6'h0D;
  localparam logic [5:0] FN_MUL  = 6'h0E;
  localparam logic [5:0] FN_DIV  = 6'h0F;

  localparam int FL_ZERO     = 0;
  localparam int FL_TRUE     = 1;
  localparam int FL_NEG      = 2;
  localparam int FL_OVERFLOW = 3;
  localparam int FL_NEGZERO  = 4;
  localparam int FL_W        = 5;

  typedef enum logic [1:0] {
    ALU_ITER_IDLE = 2'd0,
    ALU_ITER_ITER = 2'd1,
    ALU_ITER_DONE = 2'd2
  } alu_iter_state_e;

  function automatic logic is_shift(input logic [5:0] fn);
    return (fn == FN_ASL) || (fn == FN_ASR) || (fn == FN_LSL) || (fn == FN_LSR);
  endfunction

  function automatic logic [FL_W-1:0] make_flags(input logic zero, input logic neg,
                                                 input logic ovf);
    logic [FL_W-1:0] f;
    f              = '0;
    f[FL_ZERO]     = zero;
    f[FL_TRUE]     = ~zero;
    f[FL_NEG]      = neg;
    f[FL_OVERFLOW] = ovf;
    f[FL_NEGZERO]  = neg | zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_step.sv
// One iteration of the multi-cycle datapath: a 1-bit shift, one shift-add
// multiply step, or one restoring-divide step (divider only with ALU_ITER_DIV_EN).
// acc holds the shifted value / product high half / partial remainder;
// aux holds the multiplier-then-product low half / dividend-then-quotient.
module alu_iter_step
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       fn,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] aux,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] aux_nxt,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] mul_sum;

  assign mul_sum = {1'b0, acc} + (aux[0] ? {1'b0, opb} : '0);

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign rem_sh = {acc, aux[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, opb};
`endif

  // Select the single-step update for the operation in flight.
  always_comb begin
    acc_nxt = acc;
    aux_nxt = aux;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (fn)
      FN_ASL: begin
        {carry, acc_nxt} = {acc, 1'b0};
        ovf              = acc[WIDTH-1] ^ acc[WIDTH-2];
      end
      FN_LSL: {carry, acc_nxt} = {acc, 1'b0};
      FN_ASR: begin
        acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
        carry   = acc[0];
      end
      FN_LSR: begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        carry   = acc[0];
      end
      FN_MUL: begin
        acc_nxt = mul_sum[WIDTH:1];
        aux_nxt = {mul_sum[0], aux[WIDTH-1:1]};
      end
`ifdef ALU_ITER_DIV_EN
      FN_DIV: begin
        if (!trial[WIDTH]) begin
          acc_nxt = trial[WIDTH-1:0];
          aux_nxt = {aux[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt = rem_sh[WIDTH-1:0];
          aux_nxt = {aux[WIDTH-2:0], 1'b0};
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Logic/arith ops
// finish in one cycle; shifts, multiply and (with ALU_ITER_DIV_EN defined)
// divide iterate one step per cycle through alu_iter_step.
//
// state | meaning
// IDLE  | no op in flight, ready for a new op
// ITER  | multi-cycle op stepping, counter counts remaining steps minus one
// DONE  | result valid, held until the consumer takes it
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [5:0]       alu_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   alu_res,
  output logic [FL_W-1:0]  flags,
  output logic             busy
);

  // Derived from WIDTH; the counter is loaded with (steps - 1) so WIDTH steps fit.
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH - 1);

  alu_iter_state_e state, state_nxt;

  logic [5:0]       fn_q;
  logic [WIDTH-1:0] acc, aux, opb;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;

  logic [WIDTH-1:0] acc_nxt, aux_nxt;
  logic             step_carry, step_ovf;

  logic             accept, iter_op, div_op;
  logic [CNT_W-1:0] amt;
  logic [WIDTH:0]   sum_add, diff, sc_res;
  logic             sc_ovf;
  logic [WIDTH-1:0] it_res;
  logic             it_carry, it_ovf;

  assign amt     = op2[CNT_W-1:0];
  assign accept  = in_valid & in_ready;
`ifdef ALU_ITER_DIV_EN
  assign div_op  = (alu_funct == FN_DIV);
`else
  assign div_op  = 1'b0;
`endif
  // A zero-amount shift has nothing to iterate and completes like a logic op.
  assign iter_op = (is_shift(alu_funct) & (amt != '0)) | (alu_funct == FN_MUL) | div_op;

  assign sum_add = {1'b0, op1} + {1'b0, op2};
  assign diff    = {1'b0, op1} - {1'b0, op2};

  alu_iter_step #(.WIDTH(WIDTH)) u_step (
    .fn      (fn_q),
    .acc     (acc),
    .aux     (aux),
    .opb     (opb),
    .acc_nxt (acc_nxt),
    .aux_nxt (aux_nxt),
    .carry   (step_carry),
    .ovf     (step_ovf)
  );

  // Single-cycle result and overflow from the live operands.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    case (alu_funct)
      FN_ADD: begin
        sc_res = sum_add;
        sc_ovf = (op1[WIDTH-1] == op2[WIDTH-1]) & (sum_add[WIDTH-1] != op1[WIDTH-1]);
      end
      FN_SUB: begin
        sc_res = diff;
        sc_ovf = (op1[WIDTH-1] != op2[WIDTH-1]) & (diff[WIDTH-1] != op1[WIDTH-1]);
      end
      FN_AND:  sc_res = {1'b0, op1 & op2};
      FN_NAND: sc_res = {1'b0, ~(op1 & op2)};
      FN_OR:   sc_res = {1'b0, op1 | op2};
      FN_NOR:  sc_res = {1'b0, ~(op1 | op2)};
      FN_XOR:  sc_res = {1'b0, op1 ^ op2};
      FN_XNOR: sc_res = {1'b0, ~(op1 ^ op2)};
      FN_NOT:  sc_res = {1'b0, ~op1};
      FN_SLT:  sc_res = {{WIDTH{1'b0}}, ($signed(op1) < $signed(op2))};
      FN_ASL, FN_ASR, FN_LSL, FN_LSR: sc_res = {1'b0, op1};
      default: sc_res = '0;
    endcase
  end

  // Final result of an iterated op, taken from the last step's outputs.
  always_comb begin
    it_res   = acc_nxt;
    it_carry = 1'b0;
    it_ovf   = 1'b0;
    if (is_shift(fn_q)) begin
      it_carry = step_carry;
      it_ovf   = ovf_q | step_ovf;
    end else if (fn_q == FN_MUL) begin
      it_res = aux_nxt;
      it_ovf = (acc_nxt != '0);
    end
`ifdef ALU_ITER_DIV_EN
    else if (fn_q == FN_DIV) begin
      it_res = aux_nxt;
      it_ovf = (opb == '0);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ALU_ITER_IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ALU_ITER_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) state_nxt = iter_op ? ALU_ITER_ITER : ALU_ITER_DONE;
      end
      ALU_ITER_ITER: begin
        if (cnt == '0) state_nxt = ALU_ITER_DONE;
      end
      ALU_ITER_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? (iter_op ? ALU_ITER_ITER : ALU_ITER_DONE) : ALU_ITER_IDLE;
        end
      end
      default: state_nxt = ALU_ITER_IDLE;
    endcase
  end

  // Datapath: capture on accept, step during ITER, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fn_q    <= '0;
      acc     <= '0;
      aux     <= '0;
      opb     <= '0;
      cnt     <= '0;
      ovf_q   <= 1'b0;
      alu_res <= '0;
      flags   <= '0;
    end else if (accept) begin
      fn_q  <= alu_funct;
      ovf_q <= 1'b0;
      if (iter_op) begin
        cnt <= is_shift(alu_funct) ? (amt - 1'b1) : CNT_FULL;
        acc <= is_shift(alu_funct) ? op1 : '0;
        aux <= (alu_funct == FN_MUL) ? op2 : op1;
        opb <= (alu_funct == FN_MUL) ? op1 : op2;
      end else begin
        alu_res <= sc_res;
        flags   <= make_flags(sc_res[WIDTH-1:0] == '0, sc_res[WIDTH-1], sc_ovf);
      end
    end else if (state == ALU_ITER_ITER) begin
      acc   <= acc_nxt;
      aux   <= aux_nxt;
      ovf_q <= ovf_q | step_ovf;
      if (cnt == '0) begin
        alu_res <= {it_carry, it_res};
        flags   <= make_flags(it_res == '0, it_res[WIDTH-1], it_ovf);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Testbench for alu_iter (WIDTH=32): directed vector table, handshake/reset
// corner sequences and a randomised run, all checked through a scoreboard.
module tb_alu_iter;
  import alu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [5:0]  alu_funct = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [32:0] alu_res;
  logic [4:0]  flags;
  logic        busy;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .alu_funct(alu_funct), .out_valid(out_valid),
    .out_ready(out_ready), .alu_res(alu_res), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [32:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  typedef struct {
    logic [32:0] res;
    logic [4:0]  fl;
    int          lat;
    int          acc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t hd;
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   rdy_mode = 1;
  bit   head_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready owner: 0 = low, 1 = high, 2 = random (mostly high)
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  function automatic logic [4:0] mkf(input logic [31:0] r, input logic ovf);
    logic [4:0] f;
    f              = '0;
    f[FL_ZERO]     = (r == 32'd0);
    f[FL_TRUE]     = (r != 32'd0);
    f[FL_NEG]      = r[31];
    f[FL_OVERFLOW] = ovf;
    f[FL_NEGZERO]  = r[31] | (r == 32'd0);
    return f;
  endfunction

  // Behavioural reference used for the randomised run.
  function automatic vec_t model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    vec_t   v;
    int     k;
    logic [63:0] p;
    k     = int'(b[4:0]);
    v.fn  = fn; v.a = a; v.b = b;
    v.res = '0; v.ovf = 1'b0; v.lat = 1;
    case (fn)
      FN_ADD: begin
        v.res = {1'b0, a} + {1'b0, b};
        v.ovf = (a[31] == b[31]) && (v.res[31] != a[31]);
      end
      FN_SUB: begin
        v.res = {1'b0, a} - {1'b0, b};
        v.ovf = (a[31] != b[31]) && (v.res[31] != a[31]);
      end
      FN_AND:  v.res = {1'b0, a & b};
      FN_NAND: v.res = {1'b0, ~(a & b)};
      FN_OR:   v.res = {1'b0, a | b};
      FN_NOR:  v.res = {1'b0, ~(a | b)};
      FN_XOR:  v.res = {1'b0, a ^ b};
      FN_XNOR: v.res = {1'b0, ~(a ^ b)};
      FN_NOT:  v.res = {1'b0, ~a};
      FN_SLT:  v.res = ($signed(a) < $signed(b)) ? 33'd1 : 33'd0;
      FN_LSL, FN_ASL: begin
        v.res[31:0] = a << k;
        v.res[32]   = (k > 0) ? a[32-k] : 1'b0;
        if (fn == FN_ASL)
          for (int i = 1; i <= k; i++) if (a[31-i] != a[31]) v.ovf = 1'b1;
        v.lat = k + 1;
      end
      FN_LSR: begin
        v.res[31:0] = a >> k;
        v.res[32]   = (k > 0) ? a[k-1] : 1'b0;
        v.lat = k + 1;
      end
      FN_ASR: begin
        v.res[31:0] = $signed(a) >>> k;
        v.res[32]   = (k > 0) ? a[k-1] : 1'b0;
        v.lat = k + 1;
      end
      FN_MUL: begin
        p     = {32'd0, a} * {32'd0, b};
        v.res = {1'b0, p[31:0]};
        v.ovf = (p[63:32] != 32'd0);
        v.lat = 33;
      end
`ifdef ALU_ITER_DIV_EN
      FN_DIV: begin
        v.res = (b == 32'd0) ? 33'h0FFFFFFFF : {1'b0, a / b};
        v.ovf = (b == 32'd0);
        v.lat = 33;
      end
`endif
      default: v.res = '0;
    endcase
    return v;
  endfunction

  // Present one op; push its expectation at the handshake. Call just after a posedge.
  task automatic drive(input vec_t v);
    exp_t e;
    bit   ok;
    in_valid  = 1'b1;
    alu_funct = v.fn;
    op1       = v.a;
    op2       = v.b;
    ok        = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = v.res;
        e.fl  = mkf(v.res[31:0], v.ovf);
        e.lat = v.lat;
        e.acc = cyc;
        sb.push_back(e);
        ok = 1;
      end
    end
    if (!ok) fail_now("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: latency on first sight, data every valid cycle, pop on retire.
  always @(negedge clk) begin
    if (rst) begin
      head_seen = 0;
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        fail_now("out_valid_without_pending_op");
      end else begin
        hd = sb[0];
        if (!head_seen) begin
          chk("latency", 64'(cyc - hd.acc), 64'(hd.lat));
          head_seen = 1;
        end
        chk("alu_res", 64'(alu_res), 64'(hd.res));
        chk("flags", 64'(flags), 64'(hd.fl));
        if (out_ready) begin
          void'(sb.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   sel;
    logic [5:0] rfn [17];

    // fn, a, b, {carry,result}, overflow, latency
    vecs.push_back('{FN_ADD,  32'h7FFFFFFF, 32'h00000001, 33'h080000000, 1'b1, 1});
    vecs.push_back('{FN_ADD,  32'hFFFFFFFF, 32'h00000001, 33'h100000000, 1'b0, 1});
    vecs.push_back('{FN_SUB,  32'h00000003, 32'h00000005, 33'h1FFFFFFFE, 1'b0, 1});
    vecs.push_back('{FN_SUB,  32'h80000000, 32'h00000001, 33'h07FFFFFFF, 1'b1, 1});
    vecs.push_back('{FN_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 33'h000F000F0, 1'b0, 1});
    vecs.push_back('{FN_NAND, 32'hF0F0F0F0, 32'h0FF00FF0, 33'h0FF0FFF0F, 1'b0, 1});
    vecs.push_back('{FN_OR,   32'h12340000, 32'h00005678, 33'h012345678, 1'b0, 1});
    vecs.push_back('{FN_NOR,  32'h00000000, 32'h00000000, 33'h0FFFFFFFF, 1'b0, 1});
    vecs.push_back('{FN_XOR,  32'hAAAA5555, 32'hFFFF0000, 33'h055555555, 1'b0, 1});
    vecs.push_back('{FN_XNOR, 32'h12345678, 32'h12345678, 33'h0FFFFFFFF, 1'b0, 1});
    vecs.push_back('{FN_NOT,  32'h0000FFFF, 32'h00000000, 33'h0FFFF0000, 1'b0, 1});
    vecs.push_back('{FN_SLT,  32'hFFFFFFFF, 32'h00000001, 33'h000000001, 1'b0, 1});
    vecs.push_back('{FN_SLT,  32'h00000005, 32'h00000003, 33'h000000000, 1'b0, 1});
    vecs.push_back('{FN_LSL,  32'h80000001, 32'h00000003, 33'h000000008, 1'b0, 4});
    vecs.push_back('{FN_LSL,  32'h80000001, 32'h00000000, 33'h080000001, 1'b0, 1});
    vecs.push_back('{FN_LSL,  32'h80000001, 32'h00000001, 33'h100000002, 1'b0, 2});
    vecs.push_back('{FN_LSL,  32'h80000001, 32'h00000020, 33'h080000001, 1'b0, 1});
    vecs.push_back('{FN_LSR,  32'h00000006, 32'h00000002, 33'h100000001, 1'b0, 3});
    vecs.push_back('{FN_ASR,  32'h80000000, 32'h00000004, 33'h0F8000000, 1'b0, 5});
    vecs.push_back('{FN_ASL,  32'h40000000, 32'h00000001, 33'h080000000, 1'b1, 2});
    vecs.push_back('{FN_ASL,  32'h20000000, 32'h00000001, 33'h040000000, 1'b0, 2});
    vecs.push_back('{FN_ASL,  32'hC0000000, 32'h00000002, 33'h100000000, 1'b1, 3});
    vecs.push_back('{FN_MUL,  32'h00010000, 32'h00010000, 33'h000000000, 1'b1, 33});
    vecs.push_back('{FN_MUL,  32'h00000007, 32'h00000006, 33'h00000002A, 1'b0, 33});
    vecs.push_back('{FN_MUL,  32'hFFFFFFFF, 32'h00000002, 33'h0FFFFFFFE, 1'b1, 33});
`ifdef ALU_ITER_DIV_EN
    vecs.push_back('{FN_DIV,  32'd100,      32'd7,        33'h00000000E, 1'b0, 33});
    vecs.push_back('{FN_DIV,  32'h00000005, 32'h00000000, 33'h0FFFFFFFF, 1'b1, 33});
`else
    vecs.push_back('{FN_DIV,  32'd100,      32'd7,        33'h000000000, 1'b0, 1});
`endif
    vecs.push_back('{6'h3F,   32'h12345678, 32'h87654321, 33'h000000000, 1'b0, 1});

    // Reset values
    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu_res", 64'(alu_res), 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table, consumer always ready
    rdy_mode = 1;
    sync();
    for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
    drain();

    // Backpressure: SUB 3-5 held for 5 cycles, then retire and accept together
    rdy_mode = 0;
    sync();
    drive('{FN_SUB, 32'h3, 32'h5, 33'h1FFFFFFFE, 1'b0, 1});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("held_in_ready", 64'(in_ready), 64'd0);
      chk("held_out_valid", 64'(out_valid), 64'd1);
    end
    rdy_mode = 1;
    sync();
    drive('{FN_ADD, 32'h1, 32'h1, 33'h2, 1'b0, 1});
    chk("b2b_pending", 64'(sb.size()), 64'd1);
    chk("b2b_out_valid", 64'(out_valid), 64'd1);
    drain();

    // Reset during MUL iteration 10
    sync();
    drive('{FN_MUL, 32'h00010000, 32'h00010000, 33'h0, 1'b1, 33});
    chk("mul_busy", 64'(busy), 64'd1);
    chk("mul_in_ready", 64'(in_ready), 64'd0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("postrst_out_valid", 64'(out_valid), 64'd0);
    sync();
    drive('{FN_ADD, 32'd5, 32'd6, 33'd11, 1'b0, 1});
    drain();

    // Randomised run with random backpressure
    rfn = '{FN_ADD, FN_SUB, FN_AND, FN_NAND, FN_OR, FN_NOR, FN_XOR, FN_XNOR, FN_NOT,
            FN_SLT, FN_ASL, FN_ASR, FN_LSL, FN_LSR, FN_MUL, FN_DIV, 6'h3F};
    rdy_mode = 2;
    sync();
    for (int n = 0; n < 1200; n++) begin
      sel = int'($urandom_range(0, 16));
      v = model(rfn[sel], $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom);
      drive(v);
      if ($urandom_range(0, 7) == 0) sync();
    end
    rdy_mode = 1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
